booth_product_accumulator: RTL and testbench
============================================

# booth_product_accumulator

Downstream consumer of the combinational Booth multiplier. It accepts signed 8-bit products one per handshake and sums a fixed-size batch into a saturating signed accumulator. Each completed batch sum is presented on a valid/ready output with a per-batch overflow flag. This turns the multiplier into the datapath of a small dot-product / MAC unit.

## Interface

Parameters:
- PROD_W, default 8: product width, two's complement; matches the multiplier's result bus.
- ACC_W, default 9: accumulator and sum width, two's complement; must be ≥ PROD_W.
- BATCH, default 4: number of products summed per output; must be ≥ 1.

Ports:
- clk, input, 1: single clock; all state changes on its rising edge.
- rst, input, 1: reset, synchronous, active-high.
- prod_in, input, PROD_W: signed product from the multiplier.
- prod_valid, input, 1: prod_in is valid this cycle.
- prod_ready, output, 1: block accepts prod_in this cycle.
- clear, input, 1: synchronous abort of the current batch.
- sum_out, output, ACC_W: signed batch sum.
- sum_valid, output, 1: sum_out and sum_ovf are valid.
- sum_ready, input, 1: consumer takes sum_out this cycle.
- sum_ovf, output, 1: saturation occurred at least once in the reported batch.
- count, output, ceil(log2(BATCH+1)): products accepted in the current batch.

## Operation

- States: ACCUM and HOLD. Reset state is ACCUM.
- Reset values: acc=0, count=0, ovf=0, sum_out=0, sum_valid=0, sum_ovf=0.
- prod_ready = (state==ACCUM) && !clear. It depends combinationally on clear.
- Accept occurs when prod_valid && prod_ready.
- On accept, prod_in is sign-extended to ACC_W+1 bits and added to acc.
  - If the result exceeds 2^(ACC_W-1)-1, acc = max positive and ovf=1.
  - If the result is below -2^(ACC_W-1), acc = min negative and ovf=1.
  - Otherwise acc = result.
- Saturation happens at every step, not only at the end of the batch.
- Accept when count < BATCH-1: count increments.
- Accept when count == BATCH-1 (the last product of the batch):
  - sum_out ← saturated acc+prod_in.
  - sum_ovf ← ovf OR this step's saturation.
  - sum_valid ← 1.
  - acc, count and ovf clear to 0.
  - State goes to HOLD.
- HOLD: prod_ready=0. When sum_valid && sum_ready, sum_valid ← 0 and state goes to ACCUM.
- sum_out and sum_ovf stay stable while sum_valid=1. They keep their last values after handoff.
- clear: acc, count and ovf ← 0 in either state.
  - A product presented in the same cycle is not accepted.
  - clear does not affect sum_out, sum_valid, sum_ovf or the HOLD→ACCUM transition, so a finished batch is never lost.
- rst has priority over clear and over all handshakes, in any state, including mid-batch and HOLD with sum_valid=1.
- BATCH=1: every accept goes straight to HOLD.

## Timing

- Accept throughput is 1 product per cycle in ACCUM.
- Latency: sum_valid rises the cycle after the BATCH-th accept.
- HOLD lasts at least 1 cycle.
  - With sum_ready held high, prod_ready returns 1 cycle after sum_valid rises.
  - Minimum period is therefore BATCH+1 cycles per batch.
- count is registered and reflects accepts up to the previous edge.
- No combinational path from prod_valid or sum_ready to any output.
- The only combinational input→output path is clear→prod_ready.

## Test plan

- Basic batch: after reset, feed 10, 20, 30, 40 back-to-back with sum_ready=1 → sum_valid for exactly 1 cycle, one cycle after the 4th accept; sum_out=100, sum_ovf=0, count back to 0.
- Negative and saturation at the low limit: feed -128 four times → sum_out=-256 (0x100), sum_ovf=1. The third add saturates and the fourth stays saturated.
- Saturation at the high limit: feed 100, 100, -50, 10 → acc path 100, 200, 150, 160; sum_out=160, sum_ovf=0. Then feed 100, 100, 100, -20 → 255 (sat), then 235; sum_out=235, sum_ovf=1.
- Backpressure: complete a batch with sum_ready=0 for 5 cycles while prod_valid=1 → prod_ready=0 throughout, and sum_out/sum_ovf are stable. Raise sum_ready → handoff, and prod_ready=1 the next cycle with no product lost or duplicated.
- Clear mid-batch: accept 5 and 7, then assert clear together with prod_valid on prod_in=9 → 9 is not accepted and count=0. Then feed 1, 2, 3, 4 → sum_out=10.
- Reset mid-operation:
  - Assert rst with count=2 → all outputs at reset values the next cycle.
  - Repeat with rst in HOLD and sum_valid=1 → sum_valid=0 and state is ACCUM after the edge.

Source files
------------

// File: rtl/booth_product_accumulator_if.sv
// Handshake bundle between the Booth multiplier product stream, the batch
// accumulator and the downstream sum consumer.
interface booth_product_accumulator_if #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 9,
    parameter int BATCH  = 4
);
    localparam int CNT_W = $clog2(BATCH + 1);

    logic signed [PROD_W-1:0] prod_in;
    logic                     prod_valid;
    logic                     prod_ready;
    logic                     clear;
    logic signed [ACC_W-1:0]  sum_out;
    logic                     sum_valid;
    logic                     sum_ready;
    logic                     sum_ovf;
    logic [CNT_W-1:0]         count;

    // master: product source plus sum consumer; slave: the accumulator
    modport master (
        output prod_in, prod_valid, clear, sum_ready,
        input  prod_ready, sum_out, sum_valid, sum_ovf, count
    );

    modport slave (
        input  prod_in, prod_valid, clear, sum_ready,
        output prod_ready, sum_out, sum_valid, sum_ovf, count
    );
endinterface

// File: rtl/booth_product_accumulator.sv
// Sums BATCH signed products into a saturating accumulator and hands each
// batch sum, with its sticky overflow flag, to a valid/ready consumer.
module booth_product_accumulator #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 9,
    parameter int BATCH  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    booth_product_accumulator_if.slave     io
);
    localparam int CNT_W = $clog2(BATCH + 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic signed [ACC_W-1:0] sum_q, sum_d;
    logic                    sum_valid_q, sum_valid_d;
    logic                    sum_ovf_q, sum_ovf_d;

    logic signed [ACC_W:0]   prod_ext;
    logic signed [ACC_W:0]   sum_wide;
    logic signed [ACC_W-1:0] acc_sat;
    logic                    sat_hi, sat_lo, sat;
    logic                    prod_ready;
    logic                    accept;
    logic                    last;

    // One guard bit is enough: two ACC_W-bit signed values always sum exactly in ACC_W+1 bits.
    assign prod_ext = {{(ACC_W + 1 - PROD_W){io.prod_in[PROD_W-1]}}, io.prod_in};
    assign sum_wide = {acc_q[ACC_W-1], acc_q} + prod_ext;
    assign sat_hi   = !sum_wide[ACC_W] &&  sum_wide[ACC_W-1];
    assign sat_lo   =  sum_wide[ACC_W] && !sum_wide[ACC_W-1];
    assign sat      = sat_hi || sat_lo;
    assign acc_sat  = sat_hi ? ACC_MAX : (sat_lo ? ACC_MIN : sum_wide[ACC_W-1:0]);

    assign prod_ready = (state_q == ACCUM) && !io.clear;
    assign accept     = io.prod_valid && prod_ready;
    assign last       = (cnt_q == CNT_W'(BATCH - 1));

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        sum_d       = sum_q;
        sum_valid_d = sum_valid_q;
        sum_ovf_d   = sum_ovf_q;

        case (state_q)
            ACCUM: begin
                if (io.clear) begin
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end else if (accept) begin
                    if (last) begin
                        sum_d       = acc_sat;
                        sum_ovf_d   = ovf_q || sat;
                        sum_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                        state_d     = HOLD;
                    end else begin
                        acc_d = acc_sat;
                        ovf_d = ovf_q || sat;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                // clear only scrubs the (already zero) batch state; the finished sum still drains.
                if (io.clear) begin
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end
                if (sum_valid_q && io.sum_ready) begin
                    sum_valid_d = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
            sum_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
            sum_ovf_q   <= sum_ovf_d;
        end
    end

    assign io.prod_ready = prod_ready;
    assign io.sum_out    = sum_q;
    assign io.sum_valid  = sum_valid_q;
    assign io.sum_ovf    = sum_ovf_q;
    assign io.count      = cnt_q;
endmodule

// File: tb/tb_booth_product_accumulator.sv
// Directed bench: a table of per-cycle vectors plus hand-written backpressure
// and reset sequences, with hand-computed expected values.
module tb_booth_product_accumulator;
    localparam int PROD_W = 8;
    localparam int ACC_W  = 9;
    localparam int BATCH  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    booth_product_accumulator_if #(.PROD_W(PROD_W), .ACC_W(ACC_W), .BATCH(BATCH)) bus ();

    booth_product_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .BATCH(BATCH)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    typedef struct {
        int   prod;
        logic v;
        logic c;
        logic sr;
        logic er;
        int   ecnt;
        logic esv;
        int   esum;
        logic eovf;
    } vec_t;

    vec_t vecs[29];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(int prod, logic v, logic c, logic sr,
                                logic er, int ecnt, logic esv, int esum, logic eovf);
        vec_t r;
        r.prod = prod; r.v = v; r.c = c; r.sr = sr;
        r.er = er; r.ecnt = ecnt; r.esv = esv; r.esum = esum; r.eovf = eovf;
        return r;
    endfunction

    task automatic chk(string name, logic signed [31:0] act, logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Inputs are applied just after the rising edge; call check_outs before the next edge.
    task automatic drive(int prod, logic v, logic c, logic sr);
        bus.prod_in    = PROD_W'(prod);
        bus.prod_valid = v;
        bus.clear      = c;
        bus.sum_ready  = sr;
    endtask

    task automatic check_outs(string tag, logic er, int ecnt, logic esv, int esum, logic eovf);
        @(negedge clk);
        $display("%s prod=%0d v=%0b clr=%0b sr=%0b -> ready=%0b count=%0d sum_valid=%0b sum=%0d ovf=%0b",
                 tag, bus.prod_in, bus.prod_valid, bus.clear, bus.sum_ready,
                 bus.prod_ready, bus.count, bus.sum_valid, bus.sum_out, bus.sum_ovf);
        chk({tag, ".prod_ready"}, 32'(bus.prod_ready), 32'(er));
        chk({tag, ".count"},      32'(bus.count),      ecnt);
        chk({tag, ".sum_valid"},  32'(bus.sum_valid),  32'(esv));
        chk({tag, ".sum_out"},    bus.sum_out,         esum);
        chk({tag, ".sum_ovf"},    32'(bus.sum_ovf),    32'(eovf));
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(string tag, int prod, logic v, logic c, logic sr,
                         logic er, int ecnt, logic esv, int esum, logic eovf);
        drive(prod, v, c, sr);
        check_outs(tag, er, ecnt, esv, esum, eovf);
    endtask

    initial begin
        // basic batch 10+20+30+40; the HOLD cycle also offers a product that must be ignored
        vecs[0]  = mk(  10, 1, 0, 1,  1, 0, 0,    0, 0);
        vecs[1]  = mk(  20, 1, 0, 1,  1, 1, 0,    0, 0);
        vecs[2]  = mk(  30, 1, 0, 1,  1, 2, 0,    0, 0);
        vecs[3]  = mk(  40, 1, 0, 1,  1, 3, 0,    0, 0);
        vecs[4]  = mk(  99, 1, 0, 1,  0, 0, 1,  100, 0);
        // -128 x4 saturates low at the third add
        vecs[5]  = mk(-128, 1, 0, 1,  1, 0, 0,  100, 0);
        vecs[6]  = mk(-128, 1, 0, 1,  1, 1, 0,  100, 0);
        vecs[7]  = mk(-128, 1, 0, 1,  1, 2, 0,  100, 0);
        vecs[8]  = mk(-128, 1, 0, 1,  1, 3, 0,  100, 0);
        vecs[9]  = mk(  77, 1, 0, 1,  0, 0, 1, -256, 1);
        // 100,100,-50,10 stays in range
        vecs[10] = mk( 100, 1, 0, 1,  1, 0, 0, -256, 1);
        vecs[11] = mk( 100, 1, 0, 1,  1, 1, 0, -256, 1);
        vecs[12] = mk( -50, 1, 0, 1,  1, 2, 0, -256, 1);
        vecs[13] = mk(  10, 1, 0, 1,  1, 3, 0, -256, 1);
        vecs[14] = mk(   0, 0, 0, 1,  0, 0, 1,  160, 0);
        // 100,100,100,-20 saturates high then comes back down to 235
        vecs[15] = mk( 100, 1, 0, 1,  1, 0, 0,  160, 0);
        vecs[16] = mk( 100, 1, 0, 1,  1, 1, 0,  160, 0);
        vecs[17] = mk( 100, 1, 0, 1,  1, 2, 0,  160, 0);
        vecs[18] = mk( -20, 1, 0, 1,  1, 3, 0,  160, 0);
        vecs[19] = mk(   0, 0, 0, 1,  0, 0, 1,  235, 1);
        // clear mid-batch drops 5,7 and refuses 9; then 1+2+3+4
        vecs[20] = mk(   5, 1, 0, 1,  1, 0, 0,  235, 1);
        vecs[21] = mk(   7, 1, 0, 1,  1, 1, 0,  235, 1);
        vecs[22] = mk(   9, 1, 1, 1,  0, 2, 0,  235, 1);
        vecs[23] = mk(   1, 1, 0, 1,  1, 0, 0,  235, 1);
        vecs[24] = mk(   2, 1, 0, 1,  1, 1, 0,  235, 1);
        vecs[25] = mk(   3, 1, 0, 1,  1, 2, 0,  235, 1);
        vecs[26] = mk(   4, 1, 0, 1,  1, 3, 0,  235, 1);
        // clear during HOLD must not block the handoff
        vecs[27] = mk(   0, 0, 1, 1,  0, 0, 1,   10, 0);
        vecs[28] = mk(   0, 0, 0, 1,  1, 0, 0,   10, 0);

        rst = 1'b1;
        drive(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cycle("reset", 0, 0, 0, 0, 1, 0, 0, 0, 0);

        for (int i = 0; i < 29; i++) begin
            cycle($sformatf("vec%0d", i), vecs[i].prod, vecs[i].v, vecs[i].c, vecs[i].sr,
                  vecs[i].er, vecs[i].ecnt, vecs[i].esv, vecs[i].esum, vecs[i].eovf);
        end

        // backpressure: 2+3+4+5 = 14 held for 5 cycles while a product waits
        for (int i = 0; i < 4; i++)
            cycle($sformatf("bp_fill%0d", i), i + 2, 1, 0, 0, 1, i, 0, 10, 0);
        for (int i = 0; i < 5; i++)
            cycle($sformatf("bp_hold%0d", i), 50, 1, 0, 0, 0, 0, 1, 14, 0);
        cycle("bp_handoff", 50, 1, 0, 1, 0, 0, 1, 14, 0);
        cycle("bp_resume",  50, 1, 0, 1, 1, 0, 0, 14, 0);
        cycle("bp_p60",     60, 1, 0, 1, 1, 1, 0, 14, 0);
        cycle("bp_p70",     70, 1, 0, 1, 1, 2, 0, 14, 0);
        cycle("bp_pm80",   -80, 1, 0, 1, 1, 3, 0, 14, 0);
        cycle("bp_sum",      0, 0, 0, 1, 0, 0, 1, 100, 0);
        cycle("bp_idle",     0, 0, 0, 1, 1, 0, 0, 100, 0);

        // reset with count=2
        cycle("rm_p5", 5, 1, 0, 1, 1, 0, 0, 100, 0);
        cycle("rm_p6", 6, 1, 0, 1, 1, 1, 0, 100, 0);
        rst = 1'b1;
        cycle("rm_rst", 7, 1, 0, 1, 1, 2, 0, 100, 0);
        rst = 1'b0;
        cycle("rm_after", 0, 0, 0, 1, 1, 0, 0, 0, 0);

        // reset while HOLD holds an overflowed sum, with clear and sum_ready also high
        for (int i = 0; i < 4; i++)
            cycle($sformatf("rh_fill%0d", i), -128, 1, 0, 0, 1, i, 0, 0, 0);
        cycle("rh_hold", 0, 0, 0, 0, 0, 0, 1, -256, 1);
        rst = 1'b1;
        cycle("rh_rst", 0, 0, 1, 1, 0, 0, 1, -256, 1);
        rst = 1'b0;
        cycle("rh_after", 0, 0, 0, 1, 1, 0, 0, 0, 0);

        // a clean batch after reset
        for (int i = 0; i < 4; i++)
            cycle($sformatf("post%0d", i), i + 1, 1, 0, 1, 1, i, 0, 0, 0);
        cycle("post_sum", 0, 0, 0, 1, 0, 0, 1, 10, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
